// File: rtl/hdmi_rd_pkg.sv
// hdmi_rd_pkg
//   Shared definitions for the HDMI frame-buffer reader: scheduler FSM state
//   encoding, RGB565 pixel width and the black pixel sent on FIFO underflow.
package hdmi_rd_pkg;

   localparam int                PIX_W     = 16;
   localparam logic [PIX_W-1:0]  BLACK_PIX = 16'h0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FLUSH = 3'd1,
      CHECK = 3'd2,
      REQ   = 3'd3,
      DATA  = 3'd4,
      DRAIN = 3'd5
   } rd_state_t;

endpackage

// File: rtl/rd_pixel_fifo.sv
// rd_pixel_fifo
//   Single-clock synchronous FIFO with show-ahead read data.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     flush      empties the FIFO (wins over push/pop in the same cycle)
//     push/wdata write one word (ignored when full unless popping too)
//     pop/rdata  rdata is the head word; pop removes it (ignored when empty)
//     count      current occupancy (0..DEPTH)
//     empty/full occupancy flags
//   DEPTH must be a power of two so the pointers wrap naturally.
module rd_pixel_fifo #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   // A push into a full FIFO is allowed when the same cycle pops a word.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/hdmi_frame_reader.sv
// hdmi_frame_reader
//   Frame-buffer read scheduler for the HDMI output path. Fetches one active
//   frame of RGB565 pixels in BURST_LEN-pixel bursts into a local FIFO and
//   answers the timing generator's data_req with data_in one cycle later.
//   A rising edge of video_vs restarts the frame from BASE_ADDR.
//   Ports:
//     pixel_clk, sys_rst       clock, synchronous active-high reset
//     video_vs                 vsync; rising edge = frame start
//     data_req / data_in       pixel request / registered pixel (black on underflow)
//     rd_req, rd_addr, rd_ack  burst request handshake: rd_req and rd_addr are
//                              held until rd_ack is seen high on a clock edge
//     rd_valid, rd_data        read data beats
//     underflow                sticky: data_req seen with the FIFO empty
//     frame_done               one-cycle pulse after the last burst of a frame
//     dbg_state                current scheduler state (rd_state_t encoding)
//   Optional build macro HDMI_RD_STATS_EN adds underflow_cnt: a saturating
//   16-bit count of underflowing requests, cleared by reset and each vsync edge.
module hdmi_frame_reader
   import hdmi_rd_pkg::*;
#(
   parameter int                H_ACT      = 1280,
   parameter int                V_ACT      = 720,
   parameter int                BURST_LEN  = 64,
   parameter int                FIFO_DEPTH = 256,
   parameter int                ADDR_W     = 24,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
   input  logic              pixel_clk,
   input  logic              sys_rst,
   input  logic              video_vs,
   input  logic              data_req,
   output logic [PIX_W-1:0]  data_in,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic              rd_valid,
   input  logic [PIX_W-1:0]  rd_data,
   output logic              underflow,
   output logic              frame_done,
`ifdef HDMI_RD_STATS_EN
   output logic [15:0]       underflow_cnt,
`endif
   output logic [2:0]        dbg_state
);

   localparam int RW = $clog2(H_ACT * V_ACT + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   localparam logic [RW-1:0]     FRAME_PIX = RW'(H_ACT * V_ACT);
   localparam logic [RW-1:0]     REM_STEP  = RW'(BURST_LEN);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);
   localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);
   // A burst is only requested when a whole burst fits; the FIFO only drains
   // in the meantime, so the in-flight beats always have room.
   localparam logic [CW-1:0]     MAX_FILL  = CW'(FIFO_DEPTH - BURST_LEN);

   rd_state_t         state_q;
   logic              vs_q, vs_rise_q;
   logic              rd_req_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [RW-1:0]     rem_q;
   logic [BW-1:0]     beat_q;
   logic              frame_done_q;
   logic [PIX_W-1:0]  data_in_q;
   logic              underflow_q;

   logic              fifo_push, fifo_flush, fifo_empty, fifo_full;
   logic [PIX_W-1:0]  fifo_rdata;
   logic [CW-1:0]     fifo_cnt;
   logic              last_beat;

   assign fifo_push  = (state_q == DATA) && rd_valid && !fifo_full;
   assign fifo_flush = (state_q == FLUSH);
   assign last_beat  = rd_valid && (beat_q == LAST_BEAT);

   rd_pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIX_W)
   ) u_fifo (
      .clk   (pixel_clk),
      .rst   (sys_rst),
      .flush (fifo_flush),
      .push  (fifo_push),
      .wdata (rd_data),
      .pop   (data_req),
      .rdata (fifo_rdata),
      .count (fifo_cnt),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         vs_q         <= 1'b0;
         vs_rise_q    <= 1'b0;
         rd_req_q     <= 1'b0;
         rd_addr_q    <= BASE_ADDR;
         rem_q        <= '0;
         beat_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         vs_q         <= video_vs;
         vs_rise_q    <= video_vs & ~vs_q;
         frame_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (vs_rise_q) state_q <= FLUSH;
            end
            FLUSH: begin
               // Restart the frame: the pixel counter is reloaded to a full frame.
               rd_addr_q <= BASE_ADDR;
               rem_q     <= FRAME_PIX;
               beat_q    <= '0;
               state_q   <= CHECK;
            end
            CHECK: begin
               if (vs_rise_q) begin
                  state_q <= FLUSH;
               end else if (rem_q == '0) begin
                  frame_done_q <= 1'b1;
                  state_q      <= IDLE;
               end else if (fifo_cnt <= MAX_FILL) begin
                  rd_req_q <= 1'b1;
                  state_q  <= REQ;
               end
            end
            REQ: begin
               if (vs_rise_q) begin
                  rd_req_q <= 1'b0;
                  state_q  <= FLUSH;
               end else if (rd_ack) begin
                  rd_req_q  <= 1'b0;
                  rd_addr_q <= rd_addr_q + ADDR_STEP;
                  rem_q     <= rem_q - REM_STEP;
                  beat_q    <= '0;
                  state_q   <= DATA;
               end
            end
            DATA: begin
               if (rd_valid) beat_q <= beat_q + BW'(1);
               // An abort that coincides with the final beat needs no drain.
               if (vs_rise_q) state_q <= last_beat ? FLUSH : DRAIN;
               else if (last_beat) state_q <= CHECK;
            end
            DRAIN: begin
               if (rd_valid) begin
                  beat_q <= beat_q + BW'(1);
                  if (beat_q == LAST_BEAT) state_q <= FLUSH;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         data_in_q   <= BLACK_PIX;
         underflow_q <= 1'b0;
      end else if (data_req) begin
         if (fifo_empty) begin
            data_in_q   <= BLACK_PIX;
            underflow_q <= 1'b1;
         end else begin
            data_in_q <= fifo_rdata;
         end
      end
   end

`ifdef HDMI_RD_STATS_EN
   logic [15:0] ucnt_q, ucnt_d;

   always_comb begin
      ucnt_d = ucnt_q;
      if (vs_rise_q) ucnt_d = '0;
      else if (data_req && fifo_empty && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
   end

   always_ff @(posedge pixel_clk) begin
      if (sys_rst) ucnt_q <= '0;
      else         ucnt_q <= ucnt_d;
   end

   assign underflow_cnt = ucnt_q;
`endif

   assign data_in    = data_in_q;
   assign rd_req     = rd_req_q;
   assign rd_addr    = rd_addr_q;
   assign underflow  = underflow_q;
   assign frame_done = frame_done_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_hdmi_frame_reader.sv
// tb_hdmi_frame_reader
//   Directed bench for hdmi_frame_reader with an 8x2 frame, 4-pixel bursts,
//   an 8-deep FIFO and base address 24'h100. Inputs change and outputs are
//   sampled on the falling clock edge.
module tb_hdmi_frame_reader;
   import hdmi_rd_pkg::*;

   localparam logic [23:0] BASE = 24'h100;

   logic        pixel_clk = 1'b0;
   logic        sys_rst, video_vs, data_req, rd_ack, rd_valid;
   logic [15:0] rd_data, data_in;
   logic        rd_req, underflow, frame_done;
   logic [23:0] rd_addr;
   logic [2:0]  dbg_state;
`ifdef HDMI_RD_STATS_EN
   logic [15:0] underflow_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 pixel_clk = ~pixel_clk;

   hdmi_frame_reader #(
      .H_ACT      (8),
      .V_ACT      (2),
      .BURST_LEN  (4),
      .FIFO_DEPTH (8),
      .ADDR_W     (24),
      .BASE_ADDR  (BASE)
   ) dut (
      .pixel_clk  (pixel_clk),
      .sys_rst    (sys_rst),
      .video_vs   (video_vs),
      .data_req   (data_req),
      .data_in    (data_in),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_ack     (rd_ack),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .underflow  (underflow),
      .frame_done (frame_done),
`ifdef HDMI_RD_STATS_EN
      .underflow_cnt (underflow_cnt),
`endif
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   task automatic tick();
      @(negedge pixel_clk);
   endtask

   task automatic do_reset();
      sys_rst  = 1'b1;
      video_vs = 1'b0;
      data_req = 1'b0;
      rd_ack   = 1'b0;
      rd_valid = 1'b0;
      rd_data  = 16'h0;
      repeat (3) tick();
      sys_rst = 1'b0;
      tick();
   endtask

   // ---------------- drivers ----------------
   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (rd_req) ok = 1'b1;
         else tick();
      end
   endtask

   // Acks a pending request after two cycles and returns a 4-beat ramp v0..v0+3.
   task automatic serve(input logic [15:0] v0, output logic [23:0] addr,
                        output bit ok, output bit held);
      held = 1'b0;
      addr = '0;
      wait_req(ok);
      if (ok) begin
         addr = rd_addr;
         tick();
         tick();
         held = rd_req && (rd_addr == addr);
         rd_ack = 1'b1;
         tick();
         rd_ack = 1'b0;
         for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1;
            rd_data  = v0 + 16'(i);
            tick();
         end
         rd_valid = 1'b0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL reset_rd_req got=%b exp=0", rd_req); end
      checks++; if (rd_addr !== BASE) begin failures++; $display("FAIL reset_rd_addr got=%h exp=%h", rd_addr, BASE); end
      checks++; if (data_in !== 16'h0) begin failures++; $display("FAIL reset_data_in got=%h exp=0000", data_in); end
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
      checks++; if (dbg_state !== 3'(IDLE)) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
   endtask

   task automatic test_full_frame();
      logic [23:0] a;
      bit ok, held, seen;
      int fd;
      video_vs = 1'b1;
      tick(); tick();
      checks++; if (dbg_state !== 3'(FLUSH)) begin failures++; $display("FAIL vs_to_flush got=%0d exp=%0d", dbg_state, FLUSH); end
      video_vs = 1'b0;
      tick(); tick();
      checks++; if (rd_req !== 1'b1) begin failures++; $display("FAIL first_req_latency got=%b exp=1", rd_req); end
      checks++; if (rd_addr !== BASE) begin failures++; $display("FAIL first_req_addr got=%h exp=%h", rd_addr, BASE); end

      serve(16'd0, a, ok, held);
      checks++; if (!ok || a !== 24'h100) begin failures++; $display("FAIL burst0_addr got=%h ok=%b exp=000100", a, ok); end
      checks++; if (held !== 1'b1) begin failures++; $display("FAIL burst0_req_held got=%b exp=1", held); end
      serve(16'd4, a, ok, held);
      checks++; if (!ok || a !== 24'h104) begin failures++; $display("FAIL burst1_addr got=%h ok=%b exp=000104", a, ok); end

      seen = 1'b0;
      repeat (10) begin tick(); if (rd_req) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL no_req_when_full got=%b exp=0", seen); end

      for (int i = 0; i < 3; i++) begin
         data_req = 1'b1; tick();
         checks++; if (data_in !== 16'(i)) begin failures++; $display("FAIL pop%0d_data got=%h exp=%h", i, data_in, 16'(i)); end
      end
      data_req = 1'b0;
      repeat (3) tick();
      checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL no_req_after_3_pops got=%b exp=0", rd_req); end
      data_req = 1'b1; tick();
      checks++; if (data_in !== 16'd3) begin failures++; $display("FAIL pop3_data got=%h exp=0003", data_in); end
      data_req = 1'b0;

      serve(16'd8, a, ok, held);
      checks++; if (!ok || a !== 24'h108) begin failures++; $display("FAIL burst2_addr got=%h ok=%b exp=000108", a, ok); end
      for (int i = 4; i < 8; i++) begin
         data_req = 1'b1; tick();
         checks++; if (data_in !== 16'(i)) begin failures++; $display("FAIL pop%0d_data got=%h exp=%h", i, data_in, 16'(i)); end
      end
      data_req = 1'b0;
      serve(16'd12, a, ok, held);
      checks++; if (!ok || a !== 24'h10C) begin failures++; $display("FAIL burst3_addr got=%h ok=%b exp=00010c", a, ok); end

      fd = 0;
      repeat (6) begin tick(); if (frame_done) fd++; end
      checks++; if (fd !== 1) begin failures++; $display("FAIL frame_done_pulses got=%0d exp=1", fd); end
      checks++; if (dbg_state !== 3'(IDLE)) begin failures++; $display("FAIL idle_after_frame got=%0d exp=%0d", dbg_state, IDLE); end
   endtask

   task automatic test_readout();
      for (int i = 8; i < 16; i++) begin
         data_req = 1'b1; tick();
         checks++; if (data_in !== 16'(i)) begin failures++; $display("FAIL readout%0d got=%h exp=%h", i, data_in, 16'(i)); end
      end
      data_req = 1'b0;
      tick();
      checks++; if (data_in !== 16'd15) begin failures++; $display("FAIL data_in_hold got=%h exp=000f", data_in); end
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL readout_underflow got=%b exp=0", underflow); end
   endtask

   task automatic test_underflow();
      data_req = 1'b1; tick();
      checks++; if (data_in !== 16'h0000) begin failures++; $display("FAIL underflow_black got=%h exp=0000", data_in); end
      checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_set got=%b exp=1", underflow); end
      tick(); tick();
      data_req = 1'b0;
      tick();
`ifdef HDMI_RD_STATS_EN
      checks++; if (underflow_cnt !== 16'd3) begin failures++; $display("FAIL underflow_cnt got=%0d exp=3", underflow_cnt); end
`endif
      video_vs = 1'b1;
      tick(); tick(); tick();
      video_vs = 1'b0;
      checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_sticky got=%b exp=1", underflow); end
`ifdef HDMI_RD_STATS_EN
      checks++; if (underflow_cnt !== 16'd0) begin failures++; $display("FAIL underflow_cnt_clr got=%0d exp=0", underflow_cnt); end
`endif
   endtask

   task automatic test_abort();
      bit ok;
      do_reset();
      video_vs = 1'b1; tick(); video_vs = 1'b0;
      wait_req(ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL abort_req_timeout got=%b exp=1", ok); end
      rd_ack = 1'b1; tick(); rd_ack = 1'b0;
      rd_valid = 1'b1;
      rd_data = 16'h00A1; tick();
      rd_data = 16'h00A2; tick();
      rd_valid = 1'b0;
      video_vs = 1'b1;
      tick(); tick();
      checks++; if (dbg_state !== 3'(DRAIN)) begin failures++; $display("FAIL abort_drain got=%0d exp=%0d", dbg_state, DRAIN); end
      rd_valid = 1'b1;
      rd_data = 16'h00A3; tick();
      rd_data = 16'h00A4; tick();
      rd_valid = 1'b0;
      video_vs = 1'b0;
      checks++; if (dbg_state !== 3'(FLUSH)) begin failures++; $display("FAIL abort_flush got=%0d exp=%0d", dbg_state, FLUSH); end
      wait_req(ok);
      checks++; if (!ok || rd_addr !== BASE) begin failures++; $display("FAIL abort_restart_addr got=%h ok=%b exp=%h", rd_addr, ok, BASE); end
      data_req = 1'b1; tick(); data_req = 1'b0;
      checks++; if (underflow !== 1'b1 || data_in !== 16'h0) begin failures++; $display("FAIL abort_fifo_empty underflow=%b data=%h exp=1/0000", underflow, data_in); end
   endtask

   task automatic test_reset_mid_req();
      logic [23:0] a;
      bit ok, held;
      do_reset();
      video_vs = 1'b1; tick(); video_vs = 1'b0;
      serve(16'h0050, a, ok, held);
      wait_req(ok);
      checks++; if (!ok || rd_addr !== 24'h104) begin failures++; $display("FAIL rst_second_req_addr got=%h ok=%b exp=000104", rd_addr, ok); end
      sys_rst = 1'b1; tick(); sys_rst = 1'b0;
      checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL rst_mid_rd_req got=%b exp=0", rd_req); end
      checks++; if (rd_addr !== BASE) begin failures++; $display("FAIL rst_mid_rd_addr got=%h exp=%h", rd_addr, BASE); end
      rd_ack = 1'b1; tick(); rd_ack = 1'b0;
      rd_valid = 1'b1; rd_data = 16'hBEEF; tick(); rd_valid = 1'b0;
      tick();
      checks++; if (rd_req !== 1'b0 || dbg_state !== 3'(IDLE) || rd_addr !== BASE) begin
         failures++; $display("FAIL late_ack_ignored req=%b state=%0d addr=%h exp=0/%0d/%h", rd_req, dbg_state, rd_addr, IDLE, BASE);
      end
      data_req = 1'b1; tick(); data_req = 1'b0;
      checks++; if (underflow !== 1'b1 || data_in !== 16'h0) begin failures++; $display("FAIL rst_fifo_empty underflow=%b data=%h exp=1/0000", underflow, data_in); end
   endtask

   initial begin
      sys_rst  = 1'b1;
      video_vs = 1'b0;
      data_req = 1'b0;
      rd_ack   = 1'b0;
      rd_valid = 1'b0;
      rd_data  = 16'h0;
      test_reset();
      test_full_frame();
      test_readout();
      test_underflow();
      test_abort();
      test_reset_mid_req();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
